hilo_muldiv_ctrl: RTL

Multi-cycle multiply/divide sequencer for the EX stage. It accepts MULT/MULTU/DIV/DIVU operations and runs a 32-step shift-add multiplier or a restoring divider. While the operation is in flight it asserts a pipeline stall request. On completion it drives the 66-bit HI/LO write bus `{hi_we, lo_we, hi, lo}` consumed by the HI/LO register file as its EX-stage bypass/write input.

---
 rtl/hilo_muldiv_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Multi-cycle multiply/divide sequencer for the EX stage. Runs MULT, MULTU,
//   DIV and DIVU on 32-bit operands. A stall is requested while the operation
//   is in flight. On completion the HI/LO write bus is driven until EX advances.
//
//   Build option: MUL_ITER_EN
//     defined   - multiplies use a 32-step shift-add state (33-cycle latency)
//     undefined - multiplies use a single-cycle 64-bit product at acceptance,
//                 going straight from IDLE to DONE (1-cycle latency)
//     Division always uses the 32-step restoring divider.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-low reset
//   flush     in   abort the EX-stage instruction (any state -> IDLE)
//   op_valid  in   EX holds a mul/div instruction
//   op[3:0]   in   one-hot {mult, multu, div, divu}, sampled on acceptance
//   src_a     in   multiplicand / dividend
//   src_b     in   multiplier / divisor
//   advance   in   EX instruction leaves EX this cycle
//   stallreq  out  stall EX and earlier stages
//   hilo_bus  out  {hi_we, lo_we, hi[31:0], lo[31:0]}, registered, non-zero only in DONE
//   busy      out  sequencer not idle
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        advance,
  output logic        stallreq,
  output logic [65:0] hilo_bus,
  output logic        busy
);

  localparam int         DATA_W    = 32;
  localparam logic [4:0] LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef MUL_ITER_EN
    S_MUL  = 2'd1,
`endif
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement negate when n is set.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + DATA_W'(1)) : v;
  endfunction

  // Magnitude of a signed operand; unsigned operands pass through.
  // The most negative value maps onto 2^31, which is correct as unsigned.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic is_sgn);
    return neg_if(v, is_sgn & v[DATA_W-1]);
  endfunction

  // One restoring step on {remainder, dividend/quotient}. The 33-bit trial
  // difference is negative exactly when the shifted remainder is below the divisor.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [2*DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0]   d);
    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] diff;
    rem_sh = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    diff   = rem_sh - {1'b0, d};
    if (!diff[DATA_W]) return {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    else               return {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
  endfunction

`ifdef MUL_ITER_EN
  // One shift-add step on {partial product, remaining multiplier bits}.
  function automatic logic [2*DATA_W-1:0] mul_step(input logic [2*DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0]   m);
    logic [DATA_W:0] sum;
    sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, m} : '0);
    return {sum, acc[DATA_W-1:1]};
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64_if(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? (~v + (2*DATA_W)'(1)) : v;
  endfunction
`endif

  state_t              state;
  logic [4:0]          cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   a_orig;
  logic                neg_q;
  logic                neg_r;
  logic                div0;

  logic                is_mul;
  logic                is_div;
  logic                is_sgn;
  logic                accept;
  logic [2*DATA_W-1:0] div_nxt;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
`ifdef MUL_ITER_EN
  logic [2*DATA_W-1:0] mul_nxt;
  logic [2*DATA_W-1:0] prod_fix;
`else
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic [2*DATA_W-1:0]        prod_1c;
`endif

  always_comb begin
    is_mul  = (op == 4'b1000) || (op == 4'b0100);
    is_div  = (op == 4'b0010) || (op == 4'b0001);
    is_sgn  = op[3] | op[1];
    accept  = (state == S_IDLE) && op_valid && !flush && (is_mul || is_div);
    div_nxt = div_step(acc, opnd);
    // Divide by zero returns all-ones quotient and the untouched dividend.
    quo_fix = div0 ? '1     : neg_if(div_nxt[DATA_W-1:0], neg_q);
    rem_fix = div0 ? a_orig : neg_if(div_nxt[2*DATA_W-1:DATA_W], neg_r);
`ifdef MUL_ITER_EN
    mul_nxt  = mul_step(acc, opnd);
    prod_fix = neg64_if(mul_nxt, neg_q);
`else
    prod_s  = $signed({{DATA_W{src_a[DATA_W-1]}}, src_a}) * $signed({{DATA_W{src_b[DATA_W-1]}}, src_b});
    prod_u  = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
    prod_1c = op[3] ? prod_s : prod_u;
`endif
  end

  // Control state and the registered write bus.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hilo_bus <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
`ifdef MUL_ITER_EN
            state <= is_mul ? S_MUL : S_DIV;
`else
            if (is_mul) begin
              state    <= S_DONE;
              hilo_bus <= {2'b11, prod_1c};
            end else begin
              state <= S_DIV;
            end
`endif
          end
        end
`ifdef MUL_ITER_EN
        S_MUL: begin
          cnt <= cnt + 5'd1;
          if (cnt == LAST_STEP) begin
            state    <= S_DONE;
            hilo_bus <= {2'b11, prod_fix};
          end
        end
`endif
        S_DIV: begin
          cnt <= cnt + 5'd1;
          if (cnt == LAST_STEP) begin
            state    <= S_DONE;
            hilo_bus <= {2'b11, rem_fix, quo_fix};
          end
        end
        S_DONE: begin
          if (advance) begin
            state    <= S_IDLE;
            hilo_bus <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          hilo_bus <= '0;
        end
      endcase
    end
  end

  // Operand and iteration datapath; no reset needed, loaded on every acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc    <= {{DATA_W{1'b0}}, mag(src_a, is_sgn)};
      opnd   <= mag(src_b, is_sgn);
      a_orig <= src_a;
      neg_q  <= is_sgn & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      neg_r  <= is_sgn & src_a[DATA_W-1];
      div0   <= (src_b == '0);
    end else if (state == S_DIV) begin
      acc <= div_nxt;
    end
`ifdef MUL_ITER_EN
    else if (state == S_MUL) begin
      acc <= mul_nxt;
    end
`endif
  end

  assign busy     = (state != S_IDLE);
  assign stallreq = rst && op_valid && (state != S_DONE);

endmodule
